priority_encoder_hs: RTL

PRIORITY_ENCODER_HS -- requirements
Module: priority_encoder_hs

---
 rtl/priority_encoder_hs.sv | 94 +++++++++
 1 files changed

// File: rtl/priority_encoder_hs.sv
// Registered priority encoder with a valid/ready grant handshake and a pending-request vector.
// Optional round-robin arbitration is compiled when PRIORITY_ENCODER_HS_RR_EN is defined.
module priority_encoder_hs #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         ready,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         idle
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] out_q, out_d;
  logic         valid_q, valid_d;

  logic         acc;
  logic         load;
  logic [N-1:0] acc_mask;
  logic [N-1:0] cand;
  logic [W-1:0] sel;

  always_comb begin
    acc      = valid_q & ready;
    acc_mask = '0;
    if (acc) acc_mask[out_q] = 1'b1;
    cand     = pend_q & ~acc_mask;
    // set wins over clear: a request re-asserted on the accepted index survives
    pend_d   = cand | ({N{~en}} & in);
    load     = ~valid_q | acc;
    valid_d  = valid_q;
    out_d    = out_q;
    if (load) begin
      valid_d = |cand;
      if (|cand) out_d = sel;
    end
  end

`ifdef PRIORITY_ENCODER_HS_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  int unsigned  idx;
  logic         found;

  // Search downward from (last-1) mod N; the pointer follows an acceptance in the same cycle.
  always_comb begin
    ptr_d = acc ? out_q : ptr_q;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_d) + N - 1 - k) % N;
      if (!found && cand[idx]) begin
        sel   = W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) sel = W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign idle  = ~valid_q & ~(|pend_q);

endmodule
